// File: rtl/pipe_add_sub.sv
// Pipelined adder/subtractor. The carry chain is cut into STAGES registered
// segments of CHUNK bits each. A single global advance moves every stage at
// once, so a stall at the output freezes the whole pipeline and bubbles are
// never squeezed out. Subtraction is performed as a + ~b + 1: the operand is
// inverted once at entry and the stage-0 carry-in is the sub bit.
module pipe_add_sub #(
  parameter int ADDER_SIZE = 32,
  parameter int STAGES     = 4
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [ADDER_SIZE-1:0] dIn0,
  input  logic [ADDER_SIZE-1:0] dIn1,
  input  logic                  sub,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [ADDER_SIZE-1:0] dOut,
  output logic                  carry,
  output logic                  overflow,
  output logic                  zero,
  output logic                  negative
);

  localparam int CHUNK = ADDER_SIZE / STAGES;
  localparam int LAST  = STAGES - 1;
  localparam int MSB   = ADDER_SIZE - 1;

  // Per-stage registers: operands (b already inverted for sub), partial
  // result, carry out and valid.
  logic [ADDER_SIZE-1:0] a_q   [STAGES];
  logic [ADDER_SIZE-1:0] a_d   [STAGES];
  logic [ADDER_SIZE-1:0] b_q   [STAGES];
  logic [ADDER_SIZE-1:0] b_d   [STAGES];
  logic [ADDER_SIZE-1:0] res_q [STAGES];
  logic [ADDER_SIZE-1:0] res_d [STAGES];
  logic                  cy_q  [STAGES];
  logic                  cy_d  [STAGES];
  logic                  vld_q [STAGES];
  logic                  vld_d [STAGES];
  logic                  cmsb_q;
  logic                  cmsb_d;

  // Values feeding each stage: ports for stage 0, previous stage otherwise.
  logic [ADDER_SIZE-1:0] src_a   [STAGES];
  logic [ADDER_SIZE-1:0] src_b   [STAGES];
  logic [ADDER_SIZE-1:0] src_res [STAGES];
  logic                  src_c   [STAGES];
  logic                  src_v   [STAGES];

  logic advance;

  // Whole pipeline moves whenever the output slot is empty or being drained.
  always_comb begin
    advance = !vld_q[LAST] || outReady;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK:0]        sum;
    logic [ADDER_SIZE-1:0] res_new;
    logic [ADDER_SIZE-1:0] a_nxt;
    logic [ADDER_SIZE-1:0] b_nxt;
    logic [ADDER_SIZE-1:0] res_nxt;
    logic                  cy_nxt;
    logic                  vld_nxt;

    if (k == 0) begin : g_head
      assign src_a[k]   = dIn0;
      assign src_b[k]   = sub ? ~dIn1 : dIn1;
      assign src_res[k] = '0;
      assign src_c[k]   = sub;
      assign src_v[k]   = inValid;
    end else begin : g_body
      assign src_a[k]   = a_q[k-1];
      assign src_b[k]   = b_q[k-1];
      assign src_res[k] = res_q[k-1];
      assign src_c[k]   = cy_q[k-1];
      assign src_v[k]   = vld_q[k-1];
    end

    // Add this stage's chunk and compute the stage's next register values.
    always_comb begin
      sum = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
          + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, src_c[k]};
      res_new = src_res[k];
      res_new[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      a_nxt   = advance ? src_a[k] : a_q[k];
      b_nxt   = advance ? src_b[k] : b_q[k];
      res_nxt = advance ? res_new  : res_q[k];
      cy_nxt  = advance ? sum[CHUNK] : cy_q[k];
      vld_nxt = advance ? src_v[k] : vld_q[k];
    end

    assign a_d[k]   = a_nxt;
    assign b_d[k]   = b_nxt;
    assign res_d[k] = res_nxt;
    assign cy_d[k]  = cy_nxt;
    assign vld_d[k] = vld_nxt;

    // The MSB sum bit is a ^ b ^ cin, so the carry into the MSB is recovered
    // from the sum bit without a separate adder.
    if (k == LAST) begin : g_tail
      assign cmsb_d = advance ? (src_a[k][MSB] ^ src_b[k][MSB] ^ sum[CHUNK-1])
                              : cmsb_q;
    end
  end

  // The last stage's operand copies have no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_q[LAST], b_q[LAST]};

  // Pipeline registers; reset clears data and valid so nothing in flight survives.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
        cy_q[k]  <= 1'b0;
        vld_q[k] <= 1'b0;
      end
      cmsb_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        res_q[k] <= res_d[k];
        cy_q[k]  <= cy_d[k];
        vld_q[k] <= vld_d[k];
      end
      cmsb_q <= cmsb_d;
    end
  end

  // Outputs and flags straight from the final-stage registers.
  always_comb begin
    inReady  = advance;
    outValid = vld_q[LAST];
    dOut     = res_q[LAST];
    carry    = cy_q[LAST];
    overflow = cy_q[LAST] ^ cmsb_q;
    zero     = (res_q[LAST] == '0);
    negative = res_q[LAST][MSB];
  end

endmodule
